// File: rtl/input_conditioner.sv
// Raw asynchronous input front end: per channel a 2-flop synchronizer, a counter
// debounce and registered rise/fall pulses on every accepted level change.

module input_conditioner_lane #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rstN,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic busy
);

   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         // A match with the accepted level throws away any partial count.
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            clean <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

module input_conditioner #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] clean,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] busy
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      input_conditioner_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_lane (
         .clk  (clk),
         .rstN (rstN),
         .raw  (raw[i]),
         .clean(clean[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .busy (busy[i])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed latency/glitch/reset scenarios plus random
// bouncing inputs, all checked against a sample-history reference model.

module tb_input_conditioner;

   localparam int W = 2;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rstN;
   logic [W-1:0] raw, clean, rise, fall, busy;
   logic [0:0]   raw1, clean1, rise1, fall1, busy1;

   int tests  = 0;
   int errors = 0;

   // Reference: clean level changes once the synced input (raw two edges back)
   // has disagreed with it for D consecutive edges.
   logic [W-1:0] m_clean, m_rise, m_fall, m_busy;
   bit           hist[W][$];
   bit           pend[W][$];

   always #5 clk = ~clk;

   input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rstN(rstN), .raw(raw),
      .clean(clean), .rise(rise), .fall(fall), .busy(busy)
   );

   input_conditioner #(.WIDTH(1), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .rstN(rstN), .raw(raw1),
      .clean(clean1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         hist[i].delete();
         hist[i].push_back(1'b0);
         hist[i].push_back(1'b0);
         pend[i].delete();
      end
      m_clean = '0; m_rise = '0; m_fall = '0; m_busy = '0;
   endtask

   task automatic model_edge();
      for (int i = 0; i < W; i++) begin
         bit d;
         hist[i].push_back(raw[i]);
         d = hist[i][hist[i].size() - 3];
         if (hist[i].size() > 3) void'(hist[i].pop_front());
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (d == m_clean[i]) pend[i].delete();
         else begin
            pend[i].push_back(d);
            if (pend[i].size() == D) begin
               m_clean[i] = d;
               m_rise[i]  = d;
               m_fall[i]  = !d;
               pend[i].delete();
            end
         end
         m_busy[i] = (pend[i].size() != 0);
      end
   endtask

   // One rising edge (model follows), then settle to the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rstN) model_reset(); else model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0; raw = '0; raw1 = '0;
      model_reset();
      repeat (3) tick();
      tests++;
      if ({clean, rise, fall, busy} !== 8'h00) begin
         errors++;
         $display("FAIL reset: got clean=%b rise=%b fall=%b busy=%b exp all 0", clean, rise, fall, busy);
      end
      tests++;
      if ({clean1, rise1, fall1, busy1} !== 4'h0) begin
         errors++;
         $display("FAIL reset_d1: got %b exp 0000", {clean1, rise1, fall1, busy1});
      end
      rstN = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_d1_latency();
      int first = 0;
      raw1 = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (clean1[0] && first == 0) first = e;
         tests++;
         if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL d1_busy: edge %0d got %b exp 0", e, busy1);
         end
      end
      tests++;
      if (first !== 3) begin
         errors++;
         $display("FAIL d1_latency: clean rose at edge %0d exp 3", first);
      end
   endtask

   task automatic test_rise_latency();
      int first = 0;
      raw[0] = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (rise[0] && first == 0) first = e;
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL rise_model: edge %0d got %b/%b/%b/%b exp %b/%b/%b/%b", e,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
         tests++;
         if (busy[0] !== (e >= 3 && e <= 5)) begin
            errors++;
            $display("FAIL rise_busy: edge %0d got %b exp %b", e, busy[0], (e >= 3 && e <= 5));
         end
      end
      tests++;
      if (first !== 6 || clean[0] !== 1'b1) begin
         errors++;
         $display("FAIL rise_latency: rise at edge %0d clean=%b exp edge 6 clean=1", first, clean[0]);
      end
   endtask

   task automatic test_fall();
      int first = 0;
      int nrise = 0;
      int nfall = 0;
      raw[0] = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (fall[0] && first == 0) first = e;
         nfall += int'(fall[0]);
         nrise += int'(rise[0]);
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL fall_model: edge %0d got %b/%b/%b/%b exp %b/%b/%b/%b", e,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
      end
      tests++;
      if (first !== 6 || nfall !== 1 || nrise !== 0) begin
         errors++;
         $display("FAIL fall_latency: fall edge %0d falls %0d rises %0d exp 6/1/0", first, nfall, nrise);
      end
   endtask

   task automatic test_glitch();
      int seen = 0;
      raw[1] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         if (e == 4) raw[1] = 1'b0;
         tick();
         seen += int'(clean[1] | rise[1] | fall[1]);
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL glitch_model: edge %0d got %b/%b/%b/%b exp %b/%b/%b/%b", e,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
      end
      tests++;
      if (seen !== 0 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL glitch: output activity %0d busy=%b exp 0 and 0", seen, busy[1]);
      end
   endtask

   task automatic test_simultaneous();
      int first = 0;
      raw = 2'b11;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (rise != 2'b00 && first == 0) begin
            first = e;
            tests++;
            if (rise !== 2'b11 || clean !== 2'b11) begin
               errors++;
               $display("FAIL simul_pulse: rise=%b clean=%b exp 11 11", rise, clean);
            end
         end
      end
      tests++;
      if (first !== 6) begin
         errors++;
         $display("FAIL simul_latency: rise at edge %0d exp 6", first);
      end
      raw = 2'b00;
      repeat (8) tick();
   endtask

   task automatic test_bounce();
      logic [8:0] pat = 9'b111101101; // applied LSB first: 1,0,1,1,0,1,1,1,1
      int first = 0;
      int nrise = 0;
      for (int e = 1; e <= 16; e++) begin
         raw[0] = (e <= 9) ? pat[e-1] : 1'b1;
         tick();
         if (rise[0] && first == 0) first = e;
         nrise += int'(rise[0]);
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL bounce_model: edge %0d got %b/%b/%b/%b exp %b/%b/%b/%b", e,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
      end
      tests++;
      if (nrise !== 1 || first !== 11) begin
         errors++;
         $display("FAIL bounce: %0d rises first at edge %0d exp 1 at edge 11", nrise, first);
      end
      raw[0] = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset_midcount();
      int first = 0;
      int nrise = 0;
      raw[0] = 1'b1;
      repeat (4) tick();
      tests++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL midcount_busy: got %b exp 1", busy[0]);
      end
      #2 rstN = 1'b0;
      #1 model_reset();
      tests++;
      if ({clean, rise, fall, busy} !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: got %b/%b/%b/%b exp all 0", clean, rise, fall, busy);
      end
      repeat (2) tick();
      rstN = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (rise[0] && first == 0) first = e;
         nrise += int'(rise[0]);
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL post_reset_model: edge %0d got %b/%b/%b/%b exp %b/%b/%b/%b", e,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
      end
      tests++;
      if (first !== 6 || nrise !== 1) begin
         errors++;
         $display("FAIL post_reset_rise: rise at edge %0d count %0d exp 6 and 1", first, nrise);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 3) == 0) raw[i] = ~raw[i];
         tick();
         tests++;
         if ({clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL random_model: cycle %0d got %b/%b/%b/%b exp %b/%b/%b/%b", c,
                     clean, rise, fall, busy, m_clean, m_rise, m_fall, m_busy);
         end
         tests++;
         if ((rise & fall) !== '0) begin
            errors++;
            $display("FAIL random_excl: cycle %0d rise=%b fall=%b exp no overlap", c, rise, fall);
         end
      end
   endtask

   initial begin
      test_reset();
      test_d1_latency();
      test_rise_latency();
      test_fall();
      test_glitch();
      test_simultaneous();
      test_bounce();
      test_reset_midcount();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
